// File: rtl/gmii_rx_pixel_if.sv
// GMII receive byte stream in, 48-bit pixel words out to the async FIFO.
// master drives the GMII side and owns the FIFO; slave is the receiver.
interface gmii_rx_pixel_if;
  logic [7:0]  rxd;
  logic        rx_dv;
  logic        rx_er;
  logic [47:0] dout;
  logic        wr_en;
  logic        full;

  modport master (output rxd, rx_dv, rx_er, full, input dout, wr_en);
  modport slave  (input rxd, rx_dv, rx_er, full, output dout, wr_en);
endinterface

// File: rtl/gmii_rx_pixel.sv
// GMII receiver for pixel-over-Ethernet frames: validates the header and
// unpacks the payload into {vcnt, hcnt, r, g, b} words for the display FIFO.
//
// state | meaning
// IDLE  | waiting for the first preamble byte
// PRE   | inside the preamble, waiting for the SFD
// HDR   | destination MAC, source MAC and EtherType (bytes 0-13)
// PAY   | payload, six bytes per pixel word
// TAIL  | FCS/padding discarded until rx_dv falls
// DROP  | rejected frame, waiting for rx_dv to fall
module gmii_rx_pixel #(
  parameter logic [47:0] MAC_ADDR    = 48'h00_37_FF_00_00_02,
  parameter logic [15:0] ETH_TYPE    = 16'h88B5,
  parameter int          PIX_PER_PKT = 10
) (
  input  logic            rx_clk,
  input  logic            rstbtn_n,
  gmii_rx_pixel_if.slave  bus,
  output logic            pkt_ok,
  output logic            pkt_drop,
  output logic [15:0]     drop_cnt,
  output logic [15:0]     ovf_cnt
);

  localparam int WCW = (PIX_PER_PKT > 1) ? $clog2(PIX_PER_PKT) : 1;
  localparam logic [WCW-1:0] WORD_LAST = WCW'(PIX_PER_PKT - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_PAY, S_TAIL, S_DROP} state_t;

  state_t          state_q, state_d;
  logic [7:0]      rxd_q;
  logic            rx_dv_q, rx_er_q;
  logic [3:0]      byte_cnt_q;
  logic [WCW-1:0]  word_cnt_q;
  logic [39:0]     shreg_q;
  logic [47:0]     dout_q;
  logic            word_vld_q;
  logic            mac_hit_q, bc_hit_q, hdr_bad_q;
  logic            mac_hit_d, bc_hit_d, hdr_bad_d;
  logic            drop_evt, ok_evt, word_evt;
  logic [7:0]      mac_byte;

  // A full FIFO in the output cycle suppresses the strobe; the word is lost.
  assign bus.wr_en = word_vld_q & ~bus.full;
  assign bus.dout  = dout_q;

  always_comb begin
    mac_byte = 8'h00;
    case (byte_cnt_q)
      4'd0:    mac_byte = MAC_ADDR[47:40];
      4'd1:    mac_byte = MAC_ADDR[39:32];
      4'd2:    mac_byte = MAC_ADDR[31:24];
      4'd3:    mac_byte = MAC_ADDR[23:16];
      4'd4:    mac_byte = MAC_ADDR[15:8];
      4'd5:    mac_byte = MAC_ADDR[7:0];
      default: mac_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    drop_evt  = 1'b0;
    ok_evt    = 1'b0;
    word_evt  = 1'b0;
    mac_hit_d = mac_hit_q;
    bc_hit_d  = bc_hit_q;
    hdr_bad_d = hdr_bad_q;
    case (state_q)
      S_IDLE: begin
        if (rx_dv_q) state_d = (rxd_q == 8'h55) ? S_PRE : S_DROP;
      end
      S_PRE: begin
        if (!rx_dv_q) begin
          state_d  = S_IDLE;
          drop_evt = 1'b1;
        end else if (rx_er_q || (rxd_q != 8'h55 && rxd_q != 8'hD5)) begin
          state_d  = S_DROP;
          drop_evt = 1'b1;
        end else if (rxd_q == 8'hD5) begin
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (!rx_dv_q) begin
          state_d  = S_IDLE;
          drop_evt = 1'b1;
        end else if (rx_er_q) begin
          state_d  = S_DROP;
          drop_evt = 1'b1;
        end else begin
          if (byte_cnt_q <= 4'd5) begin
            mac_hit_d = mac_hit_q & (rxd_q == mac_byte);
            bc_hit_d  = bc_hit_q & (rxd_q == 8'hFF);
            if (!(mac_hit_d || bc_hit_d)) hdr_bad_d = 1'b1;
          end else if (byte_cnt_q == 4'd12 && rxd_q != ETH_TYPE[15:8]) begin
            hdr_bad_d = 1'b1;
          end else if (byte_cnt_q == 4'd13 && rxd_q != ETH_TYPE[7:0]) begin
            hdr_bad_d = 1'b1;
          end
          if (byte_cnt_q == 4'd13) begin
            if (hdr_bad_d) begin
              state_d  = S_DROP;
              drop_evt = 1'b1;
            end else begin
              state_d = S_PAY;
            end
          end
        end
      end
      S_PAY: begin
        if (!rx_dv_q) begin
          state_d  = S_IDLE;
          drop_evt = 1'b1;
        end else if (rx_er_q) begin
          state_d  = S_DROP;
          drop_evt = 1'b1;
        end else if (byte_cnt_q == 4'd5) begin
          word_evt = 1'b1;
          if (word_cnt_q == WORD_LAST) state_d = S_TAIL;
        end
      end
      S_TAIL: begin
        if (!rx_dv_q) begin
          state_d = S_IDLE;
          ok_evt  = 1'b1;
        end
      end
      S_DROP: begin
        if (!rx_dv_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge rx_clk or negedge rstbtn_n) begin
    if (!rstbtn_n) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_ff @(posedge rx_clk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      rxd_q      <= 8'h00;
      rx_dv_q    <= 1'b0;
      rx_er_q    <= 1'b0;
      byte_cnt_q <= 4'd0;
      word_cnt_q <= '0;
      shreg_q    <= 40'h0;
      dout_q     <= 48'h0;
      word_vld_q <= 1'b0;
      mac_hit_q  <= 1'b1;
      bc_hit_q   <= 1'b1;
      hdr_bad_q  <= 1'b0;
      pkt_ok     <= 1'b0;
      pkt_drop   <= 1'b0;
      drop_cnt   <= 16'h0;
      ovf_cnt    <= 16'h0;
    end else begin
      rxd_q      <= bus.rxd;
      rx_dv_q    <= bus.rx_dv;
      rx_er_q    <= bus.rx_er;
      pkt_ok     <= ok_evt;
      pkt_drop   <= drop_evt;
      word_vld_q <= word_evt;
      if (word_evt) dout_q <= {shreg_q, rxd_q};

      // Header match flags re-arm whenever the FSM is outside HDR.
      if (state_q == S_HDR) begin
        mac_hit_q <= mac_hit_d;
        bc_hit_q  <= bc_hit_d;
        hdr_bad_q <= hdr_bad_d;
      end else begin
        mac_hit_q <= 1'b1;
        bc_hit_q  <= 1'b1;
        hdr_bad_q <= 1'b0;
      end

      case (state_q)
        S_HDR:   byte_cnt_q <= (byte_cnt_q == 4'd13) ? 4'd0 : byte_cnt_q + 4'd1;
        S_PAY:   byte_cnt_q <= (byte_cnt_q == 4'd5) ? 4'd0 : byte_cnt_q + 4'd1;
        default: byte_cnt_q <= 4'd0;
      endcase

      if (state_q != S_PAY) word_cnt_q <= '0;
      else if (word_evt)    word_cnt_q <= word_cnt_q + 1'b1;

      if (state_q == S_PAY) shreg_q <= {shreg_q[31:0], rxd_q};

      if (drop_evt && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (word_vld_q && bus.full && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
    end
  end

endmodule
